mandelbrot_engine: RTL and testbench
====================================

// Module: mandelbrot_engine
// PURPOSE
//  Self-contained fixed-point Mandelbrot iterator for one pixel at a time.
//  Computes z(n+1) = z(n)^2 + c at one iteration per clock.
//  Run-time max_iter, valid/ready on input and output, output held under backpressure, abort.
//  Sits between the pixel coordinate generator and the frame/Avalon writer; N copies may be tiled.
// PARAMETERS
//  WIDTH       27  signed fixed-point word width of c and z; WIDTH-FBITS >= 4 (range +/-8)
//  FBITS       23  fraction bits (1.0 = 1<<FBITS)
//  ITER_BITS    8  iteration counter / max_iter width
//  COORD_BITS  10  pixel_x / pixel_y tag width
// PORTS
//  clk       in   1                  clock, rising edge
//  rst       in   1                  asynchronous, active-high reset
//  in_valid  in   1                  job offered
//  in_ready  out  1                  engine accepts job this cycle
//  in_x      in   COORD_BITS         pixel x tag, passed through
//  in_y      in   COORD_BITS         pixel y tag, passed through
//  in_cre    in   WIDTH (signed)     real part of c
//  in_cim    in   WIDTH (signed)     imaginary part of c
//  max_iter  in   ITER_BITS          iteration limit, sampled at acceptance
//  abort     in   1                  drop current job, no output
//  out_valid out  1                  result available
//  out_ready in   1                  consumer takes result
//  out_data  out  2*COORD_BITS+ITER_BITS+1   {inside, x, y, iter}
//  busy      out  1                  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, busy=0, z=0, k=0. in_ready=1 once rst deasserts.
//  FSM states: IDLE, ITER, HOLD.
//  Accept = in_valid & in_ready. Latches x, y, c, max_iter; zr=zi=0; k=0; goes to ITER.
//  in_ready = !abort & (IDLE | (HOLD & out_ready)); back-to-back jobs allowed when draining.
//  ITER, every cycle, in this order:
//   - sr = zr*zr>>>FBITS, si = zi*zi>>>FBITS, sx = zr*zi>>>(FBITS-1).
//     Products are full 2*WIDTH, arithmetic shift.
//   - Escape test: sr+si > (4<<FBITS). Evaluate in 2*WIDTH+1 bits; never truncated.
//   - On escape: result iter=k, inside=0 -> HOLD.
//   - Else if k==max_iter: result iter=max_iter, inside=1 -> HOLD.
//   - Else: zr <= (sr-si+cre)[WIDTH-1:0], zi <= (sx+cim)[WIDTH-1:0], k <= k+1.
//   - No overflow is possible since |z|^2 <= 4 and WIDTH-FBITS >= 4.
//  Escape test takes priority over the k==max_iter limit in the same cycle.
//  Latency: accept at cycle T; ITER covers T+1..T+1+n, where n = final iter.
//   - out_valid rises at T+n+2 (escape or inside).
//  HOLD: out_valid=1; out_data stable until out_ready.
//   - On out_ready: -> IDLE, or -> ITER if a new job is accepted in the same cycle.
//   - In that case out_valid drops for the job's iteration time; no bubble on input side.
//  abort (any state): -> IDLE next cycle, out_valid=0 next cycle, result discarded.
//   - Overrides a simultaneous accept: in_ready=0 while abort=1.
//   - abort in IDLE is a no-op.
//  rst mid-job: immediate return to reset values; no partial result emitted.
//  max_iter=0: one ITER cycle, inside=1, iter=0. z=0 never escapes at k=0.
//  Inputs other than out_ready and abort are ignored outside an accept cycle.
// TESTING
//  1. c=0, max_iter=255, out_ready=1 -> out_valid at T+257, inside=1, iter=255, tags echoed.
//  2. cre=0x0800000 (1.0), cim=0 -> z: 1,2,5 -> out_valid at T+5, inside=0, iter=3.
//  3. cre=0x1000000 (2.0) -> iter=2, inside=0.
//     cre=-2.0 (0x7000000) -> |z|^2 stays exactly 4, no escape, inside=1, iter=max_iter.
//  4. Backpressure: out_ready=0 for 10 cycles after out_valid.
//     -> out_data stable, in_ready=0, busy=1.
//     Then release out_ready with in_valid=1 -> accept in that cycle, no dropped job.
//  5. abort asserted mid-ITER with in_valid=1 -> no out_valid, in_ready=0 that cycle.
//     IDLE next cycle; the next job's result is correct.
//  6. max_iter=0 -> out_valid at T+2, inside=1, iter=0.
//     rst pulsed mid-ITER -> all outputs 0 asynchronously, no stale result afterward.

Source files
------------

// File: rtl/mandelbrot_engine.sv
// Fixed-point Mandelbrot iterator: accepts one pixel job (tags + c + max_iter),
// iterates z <= z^2 + c once per clock, and returns {inside, x, y, iter}.
// The result is held under backpressure, and abort drops the job in flight.
module mandelbrot_engine #(
  parameter int WIDTH      = 27,
  parameter int FBITS      = 23,
  parameter int ITER_BITS  = 8,
  parameter int COORD_BITS = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [COORD_BITS-1:0]               in_x,
  input  logic [COORD_BITS-1:0]               in_y,
  input  logic signed [WIDTH-1:0]             in_cre,
  input  logic signed [WIDTH-1:0]             in_cim,
  input  logic [ITER_BITS-1:0]                max_iter,
  input  logic                                abort,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*COORD_BITS+ITER_BITS:0]     out_data,
  output logic                                busy
);

  localparam int PW = 2 * WIDTH;
  localparam int OW = 2 * COORD_BITS + ITER_BITS + 1;
  // |z|^2 limit, in the widened magnitude format so the compare never truncates.
  localparam logic signed [PW:0] ESC_LIM = (PW+1)'(4) <<< FBITS;

  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [COORD_BITS-1:0]   x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] cre_q, cre_d, cim_q, cim_d;
  logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
  logic [ITER_BITS-1:0]    max_q, max_d, k_q, k_d;
  logic [OW-1:0]           out_data_q, out_data_d;

  logic                    accept;
  logic signed [PW-1:0]    sr, si, sx;
  logic signed [PW:0]      mag;
  logic                    escape;

  // Full-precision squares and cross term; arithmetic shifts keep the sign.
  assign sr     = (PW'(zr_q) * PW'(zr_q)) >>> FBITS;
  assign si     = (PW'(zi_q) * PW'(zi_q)) >>> FBITS;
  assign sx     = (PW'(zr_q) * PW'(zi_q)) >>> (FBITS - 1);
  assign mag    = (PW+1)'(sr) + (PW+1)'(si);
  assign escape = mag > ESC_LIM;

  // Abort blocks acceptance; a held result can be swapped for a new job in one cycle.
  assign in_ready  = !rst && !abort &&
                     ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

  // Next-state and datapath update for the IDLE/ITER/HOLD controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cre_d      = cre_q;
    cim_d      = cim_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    max_d      = max_q;
    k_d        = k_q;
    out_data_d = out_data_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ITER: begin
          if (escape) begin
            out_data_d = {1'b0, x_q, y_q, k_q};
            state_d    = HOLD;
          end else if (k_q == max_q) begin
            out_data_d = {1'b1, x_q, y_q, max_q};
            state_d    = HOLD;
          end else begin
            zr_d = WIDTH'(sr - si + PW'(cre_q));
            zi_d = WIDTH'(sx + PW'(cim_q));
            k_d  = k_q + ITER_BITS'(1);
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: ;
      endcase
    end

    // A job can only be accepted from IDLE or a draining HOLD, never under abort.
    if (accept) begin
      x_d     = in_x;
      y_d     = in_y;
      cre_d   = in_cre;
      cim_d   = in_cim;
      max_d   = max_iter;
      zr_d    = '0;
      zi_d    = '0;
      k_d     = '0;
      state_d = ITER;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so a reset mid-job leaves no stale z, k or result.
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cre_q      <= '0;
      cim_q      <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      max_q      <= '0;
      k_q        <= '0;
      out_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from the old values.
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cre_q      <= cre_d;
      cim_q      <= cim_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      max_q      <= max_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Scoreboard bench for mandelbrot_engine: a software fixed-point model pushes the
// expected {inside, x, y, iter} at acceptance, and a monitor pops it on each handshake.
module tb_mandelbrot_engine;

  localparam int WIDTH = 27;
  localparam int FBITS = 23;
  localparam int IB    = 8;
  localparam int CB    = 10;
  localparam int OW    = 2 * CB + IB + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [CB-1:0]           in_x = '0;
  logic [CB-1:0]           in_y = '0;
  logic signed [WIDTH-1:0] in_cre = '0;
  logic signed [WIDTH-1:0] in_cim = '0;
  logic [IB-1:0]           max_iter = '0;
  logic                    abort = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [OW-1:0]           out_data;
  logic                    busy;

  mandelbrot_engine #(.WIDTH(WIDTH), .FBITS(FBITS), .ITER_BITS(IB), .COORD_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cre(in_cre), .in_cim(in_cim),
    .max_iter(max_iter), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [OW-1:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint sx27(input longint v);
    longint t;
    t = v <<< (64 - WIDTH);
    return t >>> (64 - WIDTH);
  endfunction

  // Reference iteration in 64-bit integers.
  function automatic logic [OW-1:0] model(input logic [CB-1:0] x, input logic [CB-1:0] y,
                                          input longint cre, input longint cim, input int mx);
    longint zr, zi, sr, si, sx;
    zr = 0;
    zi = 0;
    for (int k = 0; k <= 255; k++) begin
      sr = (zr * zr) >>> FBITS;
      si = (zi * zi) >>> FBITS;
      sx = (zr * zi) >>> (FBITS - 1);
      if (sr + si > (longint'(4) <<< FBITS)) return {1'b0, x, y, IB'(k)};
      if (k == mx) return {1'b1, x, y, IB'(mx)};
      zr = sx27(sr - si + cre);
      zi = sx27(sx + cim);
    end
    return '0;
  endfunction

  function automatic longint fx(input real r);
    return longint'($rtoi(r * 8388608.0));
  endfunction

  // Handshake monitor: compares every consumed result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_out", 1, 0);
      else check("out_data", out_data, sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_job(input logic [CB-1:0] x, input logic [CB-1:0] y, input longint cre,
                          input longint cim, input int mx, output int c0, output logic [OW-1:0] e);
    logic ok;
    in_x = x; in_y = y; in_cre = WIDTH'(cre); in_cim = WIDTH'(cim);
    max_iter = IB'(mx); in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      step();
    end
    check("accept", ok, 1);
    c0 = cyc;
    e  = model(x, y, cre, cim, mx);
    if (ok) sb_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_lat(input string tag, input int c0, input int exp_lat);
    logic ok;
    int   lat;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    lat = ok ? (cyc - c0) : -1;
    check(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_job(input string tag, input logic [CB-1:0] x, input logic [CB-1:0] y,
                         input longint cre, input longint cim, input int mx);
    int c0;
    logic [OW-1:0] e;
    send_job(x, y, cre, cim, mx, c0, e);
    wait_lat(tag, c0, int'(e[IB-1:0]) + 2);
    step();
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
  endtask

  initial begin
    int c0, rc, hits, bad_stable, bad_ready, bad_busy;
    logic [OW-1:0] e, snap;

    // Reset values, including in_ready held low during reset.
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // c = 0: never escapes; 255 iterations, inside.
    run_job("lat_c0", 10'd17, 10'd42, 0, 0, 255);
    // c = 1.0 escapes at iter 3; c = 2.0 at iter 2; c = -2.0 sits exactly on |z|^2 = 4.
    run_job("lat_c1", 10'd1, 10'd2, fx(1.0), 0, 255);
    run_job("lat_c2", 10'd3, 10'd4, fx(2.0), 0, 255);
    run_job("lat_cm2", 10'd1023, 10'd0, fx(-2.0), 0, 100);
    // max_iter = 0: one ITER cycle, inside.
    run_job("lat_max0", 10'd9, 10'd9, fx(1.5), fx(1.5), 0);

    // Assorted points, then random c in [-2, 2).
    run_job("lat_p0", 10'd100, 10'd200, fx(-0.75), fx(0.1), 40);
    run_job("lat_p1", 10'd101, 10'd201, fx(0.25), fx(0.5), 40);
    run_job("lat_p2", 10'd102, 10'd202, fx(-1.25), fx(0.25), 40);
    run_job("lat_p3", 10'd103, 10'd203, fx(0.3), fx(-0.6), 40);
    for (int i = 0; i < 4; i++) begin
      longint r_re, r_im;
      r_re = longint'($urandom_range(0, 32'h1FFFFFF)) - longint'(32'h1000000);
      r_im = longint'($urandom_range(0, 32'h1FFFFFF)) - longint'(32'h1000000);
      run_job("lat_rand", CB'(i), CB'(i + 500), r_re, r_im, 60);
    end

    // Backpressure: result held for 10 cycles, then released with a new job offered.
    out_ready = 1'b0;
    send_job(10'd4, 10'd5, fx(1.0), 0, 255, c0, e);
    wait_lat("bp_lat", c0, 5);
    snap = out_data;
    check("bp_data", snap, e);
    bad_stable = 0; bad_ready = 0; bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (out_data !== snap || !out_valid) bad_stable++;
      if (in_ready !== 1'b0) bad_ready++;
      if (busy !== 1'b1) bad_busy++;
    end
    check("bp_stable", 64'(bad_stable), 0);
    check("bp_in_ready_low", 64'(bad_ready), 0);
    check("bp_busy", 64'(bad_busy), 0);
    step();
    out_ready = 1'b1;
    rc = cyc;
    send_job(10'd6, 10'd7, fx(2.0), 0, 255, c0, e);
    check("bp_same_cycle_accept", 64'(c0), 64'(rc));
    wait_lat("bp_next_lat", c0, 4);
    step();

    // Abort mid-ITER with a competing job offered.
    send_job(10'd7, 10'd7, 0, 0, 255, c0, e);
    repeat (5) step();
    abort = 1'b1;
    in_valid = 1'b1; in_cre = WIDTH'(fx(1.0)); in_cim = '0; max_iter = 8'd10;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy_same_cycle", busy, 1);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("abort_idle", busy, 0);
    count_valid(30, hits);
    check("abort_no_output", 64'(hits), 0);
    step();
    run_job("post_abort", 10'd8, 10'd8, fx(-0.5), fx(0.5), 30);

    // Reset mid-ITER: outputs drop asynchronously, nothing emitted afterwards.
    send_job(10'd11, 10'd12, 0, 0, 255, c0, e);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", out_data, 0);
    sb_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_again", in_ready, 1);
    count_valid(280, hits);
    check("mid_rst_no_stale", 64'(hits), 0);
    step();
    run_job("post_rst", 10'd13, 10'd14, fx(1.0), 0, 255);

    repeat (3) step();
    check("sb_empty", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
